// File: rtl/fifo_stream_pkg.sv
// Shared types for the FIFO read-side streamer: controller states and skid depth.
package fifo_stream_pkg;
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      DRAIN = 2'd1,
      DONE  = 2'd2
   } rd_state_t;

   localparam int SKID_DEPTH = 2;
endpackage

// File: rtl/stream_skid_buf.sv
// Two-entry circular buffer holding {last, data}; accepts a write and a pop in the same clk.
module stream_skid_buf
   import fifo_stream_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             wr,
   input  logic [WIDTH:0]   wr_data,
   input  logic             rd,
   output logic [1:0]       count,
   output logic [WIDTH:0]   head
);

   logic [WIDTH:0] mem_r [SKID_DEPTH];
   logic           wr_ptr_r;
   logic           rd_ptr_r;
   logic [1:0]     count_r;

   // Storage, pointers and occupancy; a write and a pop together leave the count unchanged.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < SKID_DEPTH; i++) begin
            mem_r[i] <= {(WIDTH+1){1'b0}};
         end
         wr_ptr_r <= 1'b0;
         rd_ptr_r <= 1'b0;
         count_r  <= 2'd0;
      end else begin
         if (wr) begin
            mem_r[wr_ptr_r] <= wr_data;
            wr_ptr_r        <= ~wr_ptr_r;
         end
         if (rd) begin
            rd_ptr_r <= ~rd_ptr_r;
         end
         case ({wr, rd})
            2'b10:   count_r <= count_r + 2'd1;
            2'b01:   count_r <= count_r - 2'd1;
            default: count_r <= count_r;
         endcase
      end
   end

   assign count = count_r;
   assign head  = mem_r[rd_ptr_r];

endmodule

// File: rtl/fifo_rd_streamer.sv
// Drains N words from a 1-cycle-latency sync FIFO into a valid/ready stream with last/done.
module fifo_rd_streamer
   import fifo_stream_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int ADDR  = 6
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic [ADDR:0]     cmd_len,
   input  logic              fifo_empty,
   output logic              fifo_read,
   input  logic [WIDTH-1:0]  fifo_data,
   output logic              m_valid,
   input  logic              m_ready,
   output logic [WIDTH-1:0]  m_data,
   output logic              m_last,
   output logic              busy,
   output logic              done
);

   localparam logic [ADDR:0] LEN_ONE = {{ADDR{1'b0}}, 1'b1};

   rd_state_t      state_r;
   rd_state_t      state_nxt_s;
   logic [ADDR:0]  issued_r;
   logic [ADDR:0]  len_r;
   logic           inflight_r;
   logic           inflight_last_r;
   logic [1:0]     buf_count_s;
   logic [WIDTH:0] buf_head_s;
   logic           accept_s;
   logic           pop_s;
   logic           valid_s;
   logic [2:0]     occ_s;
   logic           fifo_read_s;

   assign accept_s = (state_r == IDLE) && cmd_valid;
   assign valid_s  = (buf_count_s != 2'd0);
   assign pop_s    = valid_s && m_ready;

   // Words held or in flight after this clk's pop; a read is only issued if it still fits.
   assign occ_s       = {1'b0, buf_count_s} + {2'b00, inflight_r} - {2'b00, pop_s};
   assign fifo_read_s = (state_r == DRAIN) && !fifo_empty && (issued_r < len_r) && (occ_s < 3'd2);

   // Next-state decode for the drain controller.
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         IDLE: begin
            if (cmd_valid) begin
               state_nxt_s = (cmd_len == {(ADDR+1){1'b0}}) ? DONE : DRAIN;
            end else begin
               state_nxt_s = IDLE;
            end
         end
         DRAIN: begin
            if (pop_s && buf_head_s[WIDTH]) begin
               state_nxt_s = DONE;
            end else begin
               state_nxt_s = DRAIN;
            end
         end
         DONE:    state_nxt_s = IDLE;
         default: state_nxt_s = IDLE;
      endcase
   end

   // State, command length, read counter and the one-deep in-flight tracker.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r         <= IDLE;
         issued_r        <= {(ADDR+1){1'b0}};
         len_r           <= {(ADDR+1){1'b0}};
         inflight_r      <= 1'b0;
         inflight_last_r <= 1'b0;
      end else begin
         state_r <= state_nxt_s;
         if (accept_s) begin
            issued_r <= {(ADDR+1){1'b0}};
            len_r    <= cmd_len;
         end else if (fifo_read_s) begin
            issued_r <= issued_r + LEN_ONE;
         end
         inflight_r      <= fifo_read_s;
         inflight_last_r <= fifo_read_s && ((issued_r + LEN_ONE) == len_r);
      end
   end

   stream_skid_buf #(
      .WIDTH (WIDTH)
   ) u_skid (
      .clk     (clk),
      .rst     (rst),
      .wr      (inflight_r),
      .wr_data ({inflight_last_r, fifo_data}),
      .rd      (pop_s),
      .count   (buf_count_s),
      .head    (buf_head_s)
   );

   // Stale buffer contents are masked so idle outputs read as zero.
   assign m_valid   = valid_s;
   assign m_data    = valid_s ? buf_head_s[WIDTH-1:0] : {WIDTH{1'b0}};
   assign m_last    = valid_s && buf_head_s[WIDTH];
   assign fifo_read = fifo_read_s;
   assign cmd_ready = (state_r == IDLE);
   assign busy      = (state_r != IDLE);
   assign done      = (state_r == DONE);

endmodule
